code_entry_checker: RTL and testbench
=====================================

CODE_ENTRY_CHECKER -- requirements
Module: code_entry_checker

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, meaning the number of decimal digits per code (2..8).
REQ-002 SHALL have parameter MAX_FAILS, default 3, meaning the number of consecutive wrong attempts that trigger lockout.
REQ-003 SHALL have parameter UNLOCK_CYCLES, default 100000000, meaning the clocks the safe stays open before auto-relock.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 500000000, meaning the clocks of input lockout.
REQ-005 SHALL have parameter DEFAULT_CODE, default 16'h1234, meaning the reset code as 4-bit BCD digits, first digit in the MS nibble.
REQ-006 SHALL have port clk, input, 1 bit, meaning the system clock (one clock).
REQ-007 SHALL have port sys_reset, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-008 SHALL have port current_digit, input, 4 bits, meaning the digit currently shown by the up/down selector.
REQ-009 SHALL have port enter_pulse, input, 1 bit, meaning a 1-clock request to accept current_digit.
REQ-010 SHALL have port clear_pulse, input, 1 bit, meaning a 1-clock request to abort or restart the entry.
REQ-011 SHALL have port lock_pulse, input, 1 bit, meaning a 1-clock request to relock immediately.
REQ-012 SHALL have port program_pulse, input, 1 bit, meaning a 1-clock request to start a code change (honoured only in UNLOCKED).
REQ-013 SHALL have port enable_digit_select, output, 1 bit, meaning the digit selector may change; high only in ENTRY and PROGRAM.
REQ-014 SHALL have port digit_index, output, $clog2(CODE_LEN) bits, meaning the position of the next digit to accept.
REQ-015 SHALL have port digit_accepted, output, 1 bit, meaning a 1-clock pulse on every accepted digit.
REQ-016 SHALL have port unlocked, output, 1 bit, meaning the safe is open; high only in UNLOCKED.
REQ-017 SHALL have port locked_out, output, 1 bit, meaning entry is disabled; high only in LOCKOUT.
REQ-018 SHALL have port fail_pulse, output, 1 bit, meaning a 1-clock pulse on each wrong attempt.
REQ-019 SHALL have port fail_count, output, $clog2(MAX_FAILS+1) bits, meaning the number of consecutive wrong attempts.

Function
REQ-020 SHALL implement the states ENTRY, CHECK, UNLOCKED, PROGRAM and LOCKOUT.
REQ-021 SHALL decode enable_digit_select, unlocked and locked_out from the registered state only.
REQ-022 In ENTRY, an enter_pulse SHALL store current_digit into entry[digit_index] and pulse digit_accepted.
REQ-023 In ENTRY, after an accepted digit, digit_index SHALL increment; when the accepted digit was at index CODE_LEN-1, the block SHALL go to CHECK with index 0.
REQ-024 In ENTRY or PROGRAM, clear_pulse SHALL win over a same-cycle enter_pulse: the digit is discarded and digit_index returns to 0.
REQ-025 CHECK SHALL last exactly one cycle and compare all CODE_LEN digits against the stored code.
REQ-026 On a CHECK match: go to UNLOCKED, set fail_count to 0 and load the timer with UNLOCK_CYCLES-1.
REQ-027 On a CHECK mismatch: increment fail_count and pulse fail_pulse; go to LOCKOUT with the timer loaded with LOCKOUT_CYCLES-1 when the new count equals MAX_FAILS, else go to ENTRY.
REQ-028 In UNLOCKED, the timer SHALL decrement each cycle; at 0, lock_pulse or clear_pulse the block SHALL go to ENTRY, with lock_pulse taking priority over program_pulse.
REQ-029 In UNLOCKED, program_pulse SHALL go to PROGRAM with index 0.
REQ-030 PROGRAM SHALL accept digits as ENTRY does.
REQ-031 After the last PROGRAM digit, all CODE_LEN digits SHALL be written to the stored code in one cycle and the block SHALL go to ENTRY.
REQ-032 In PROGRAM, clear_pulse or lock_pulse SHALL abort to ENTRY with the old code kept.
REQ-033 In LOCKOUT, the timer SHALL decrement each cycle; at 0 the block SHALL go to ENTRY with fail_count 0.
REQ-034 In LOCKOUT, all input pulses SHALL be ignored.
REQ-035 Pulses not listed for the current state SHALL be ignored; a current_digit above 9 SHALL be stored as-is and fail the compare.

Reset
REQ-036 While sys_reset is high, the block SHALL immediately force: state ENTRY, digit_index 0, fail_count 0, timer 0, entry buffer 0, stored code DEFAULT_CODE, all pulse outputs 0, unlocked 0, locked_out 0, enable_digit_select 1.
REQ-037 A reset in any state SHALL discard a partial entry or program sequence; a reset during PROGRAM SHALL leave the stored code equal to DEFAULT_CODE.

Structure
REQ-038 A shared package safe_pkg SHALL hold the state enum, the BCD digit typedef (4 bits) and the DIGIT_MAX=9 constant.
REQ-039 One sub-module, safe_countdown, SHALL provide the down-counter (load, enable, zero flag) shared by the unlock and lockout timers.

Verification (code 1234, UNLOCK_CYCLES=20, LOCKOUT_CYCLES=50)
REQ-040 Entering 1,2,3,4 SHALL raise unlocked 2 cycles after the 4th enter_pulse, keep it high 20 cycles, then return to ENTRY.
REQ-041 Entering 1,2,3,5 SHALL produce fail_pulse and fail_count=1; three wrong codes SHALL give locked_out for 50 cycles with enters ignored, then fail_count=0.
REQ-042 Entering 1,2 then clear_pulse with a same-cycle enter_pulse, then 1,2,3,4, SHALL give digit_index 0 after the clear and then unlock.
REQ-043 Unlock, program_pulse, enter 9,0,0,7, then relock: 1234 SHALL fail and 9007 SHALL unlock.
REQ-044 Program 9,0 then lock_pulse SHALL keep 1234 valid.
REQ-045 sys_reset asserted mid-LOCKOUT or after programming SHALL give ENTRY within the same cycle, with code 1234 and fail_count 0.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared types and constants for the code-entry safe controller.
package safe_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCKED,
    ST_PROGRAM,
    ST_LOCKOUT
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;

  function automatic logic is_bcd(input bcd_t d);
    return d <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/safe_countdown.sv
// Loadable down-counter shared by the unlock and lockout timers; holds at zero.
module safe_countdown #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/code_entry_checker.sv
// Digit-by-digit safe code entry with compare, timed unlock, code programming
// and lockout after repeated wrong attempts.
module code_entry_checker
  import safe_pkg::*;
#(
  parameter int CODE_LEN       = 4,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 100000000,
  parameter int LOCKOUT_CYCLES = 500000000,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                           clk,
  input  logic                           sys_reset,
  input  logic [3:0]                     current_digit,
  input  logic                           enter_pulse,
  input  logic                           clear_pulse,
  input  logic                           lock_pulse,
  input  logic                           program_pulse,
  output logic                           enable_digit_select,
  output logic [$clog2(CODE_LEN)-1:0]    digit_index,
  output logic                           digit_accepted,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic                           fail_pulse,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int IW   = $clog2(CODE_LEN);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = 4 * CODE_LEN;

  localparam logic [IW-1:0] LAST_IDX     = IW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_FAILS);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [CW-1:0] entry_q, entry_d;
  logic [CW-1:0] code_q, code_d;
  logic          acc_q, acc_d;
  logic          failp_q, failp_d;

  logic [CW-1:0]       entry_ins;
  logic [CODE_LEN-1:0] digit_ok;
  logic [FW-1:0]       fail_inc;
  logic                match;
  logic                timer_load, timer_en, timer_zero;
  logic [TW-1:0]       timer_load_val;

  // Entry buffer holds digit 0 in the MS nibble, matching the stored code layout.
  for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_digit
    localparam int LSB = 4 * (CODE_LEN - 1 - gi);
    assign entry_ins[LSB +: 4] = (idx_q == IW'(gi)) ? current_digit : entry_q[LSB +: 4];
    assign digit_ok[gi]        = is_bcd(entry_q[LSB +: 4]);
  end

  assign match    = (entry_q == code_q) && (&digit_ok);
  assign fail_inc = fail_q + FW'(1);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    fail_d         = fail_q;
    entry_d        = entry_q;
    code_d         = code_q;
    acc_d          = 1'b0;
    failp_d        = 1'b0;
    timer_load     = 1'b0;
    timer_load_val = '0;
    timer_en       = 1'b0;
    case (state_q)
      ST_ENTRY, ST_PROGRAM: begin
        if (clear_pulse || ((state_q == ST_PROGRAM) && lock_pulse)) begin
          idx_d   = '0;
          state_d = ST_ENTRY;
        end else if (enter_pulse) begin
          entry_d = entry_ins;
          acc_d   = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (state_q == ST_ENTRY) begin
              state_d = ST_CHECK;
            end else begin
              code_d  = entry_ins;
              state_d = ST_ENTRY;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_CHECK: begin
        if (match) begin
          state_d        = ST_UNLOCKED;
          fail_d         = '0;
          timer_load     = 1'b1;
          timer_load_val = UNLOCK_LOAD;
        end else begin
          fail_d  = fail_inc;
          failp_d = 1'b1;
          if (fail_inc == FAIL_LIMIT) begin
            state_d        = ST_LOCKOUT;
            timer_load     = 1'b1;
            timer_load_val = LOCKOUT_LOAD;
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end
      ST_UNLOCKED: begin
        timer_en = 1'b1;
        if (lock_pulse || clear_pulse || timer_zero) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end else if (program_pulse) begin
          state_d = ST_PROGRAM;
          idx_d   = '0;
        end
      end
      ST_LOCKOUT: begin
        timer_en = 1'b1;
        if (timer_zero) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= ST_ENTRY;
      idx_q   <= '0;
      fail_q  <= '0;
      entry_q <= '0;
      code_q  <= DEFAULT_CODE;
      acc_q   <= 1'b0;
      failp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      entry_q <= entry_d;
      code_q  <= code_d;
      acc_q   <= acc_d;
      failp_q <= failp_d;
    end
  end

  safe_countdown #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (sys_reset),
    .load       (timer_load),
    .load_value (timer_load_val),
    .enable     (timer_en),
    .zero       (timer_zero)
  );

  assign enable_digit_select = (state_q == ST_ENTRY) || (state_q == ST_PROGRAM);
  assign unlocked            = (state_q == ST_UNLOCKED);
  assign locked_out          = (state_q == ST_LOCKOUT);
  assign digit_index         = idx_q;
  assign digit_accepted      = acc_q;
  assign fail_pulse          = failp_q;
  assign fail_count          = fail_q;

endmodule

// File: tb/tb_code_entry_checker.sv
// Self-checking bench for code_entry_checker: table of code attempts plus
// hand-written timing, clear, program, lockout and reset sequences.
module tb_code_entry_checker;

  logic       clk = 1'b0;
  logic       sys_reset;
  logic [3:0] current_digit;
  logic       enter_pulse, clear_pulse, lock_pulse, program_pulse;
  logic       enable_digit_select, digit_accepted, unlocked, locked_out, fail_pulse;
  logic [1:0] digit_index;
  logic [1:0] fail_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] code;
    logic        exp_unlock;
    logic        exp_lockout;
    logic [1:0]  exp_fails;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  code_entry_checker #(
    .CODE_LEN       (4),
    .MAX_FAILS      (3),
    .UNLOCK_CYCLES  (20),
    .LOCKOUT_CYCLES (50),
    .DEFAULT_CODE   (16'h1234)
  ) dut (
    .clk                 (clk),
    .sys_reset           (sys_reset),
    .current_digit       (current_digit),
    .enter_pulse         (enter_pulse),
    .clear_pulse         (clear_pulse),
    .lock_pulse          (lock_pulse),
    .program_pulse       (program_pulse),
    .enable_digit_select (enable_digit_select),
    .digit_index         (digit_index),
    .digit_accepted      (digit_accepted),
    .unlocked            (unlocked),
    .locked_out          (locked_out),
    .fail_pulse          (fail_pulse),
    .fail_count          (fail_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    current_digit = d;
    enter_pulse   = 1'b1;
    tick();
    enter_pulse   = 1'b0;
    check("digit_accepted", {31'b0, digit_accepted}, 32'd1);
  endtask

  task automatic attempt(input logic [15:0] code, input logic eu, input logic el, input logic [1:0] ef);
    vec_t v;
    vec_t e;
    v.code = code; v.exp_unlock = eu; v.exp_lockout = el; v.exp_fails = ef;
    sb_q.push_back(v);
    for (int i = 0; i < 4; i++) press(code[15-4*i -: 4]);
    check("unlocked_during_check", {31'b0, unlocked}, 32'd0);
    tick();
    e = sb_q.pop_front();
    check("unlocked", {31'b0, unlocked}, {31'b0, e.exp_unlock});
    check("fail_pulse", {31'b0, fail_pulse}, {31'b0, ~e.exp_unlock});
    check("locked_out", {31'b0, locked_out}, {31'b0, e.exp_lockout});
    check("fail_count", {30'b0, fail_count}, {30'b0, e.exp_fails});
    $display("attempt code=%h unlocked=%0b fail_pulse=%0b fail_count=%0d locked_out=%0b",
             code, unlocked, fail_pulse, fail_count, locked_out);
  endtask

  task automatic relock();
    lock_pulse = 1'b1;
    tick();
    lock_pulse = 1'b0;
    check("relock_unlocked", {31'b0, unlocked}, 32'd0);
    check("relock_enable", {31'b0, enable_digit_select}, 32'd1);
    $display("relock unlocked=%0b", unlocked);
  endtask

  task automatic start_program();
    program_pulse = 1'b1;
    tick();
    program_pulse = 1'b0;
    check("prog_unlocked", {31'b0, unlocked}, 32'd0);
    check("prog_enable", {31'b0, enable_digit_select}, 32'd1);
    check("prog_index", {30'b0, digit_index}, 32'd0);
    $display("program start enable_digit_select=%0b", enable_digit_select);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, {31'b0, enable_digit_select}, 32'd1);
    check({tag, "_unlocked"}, {31'b0, unlocked}, 32'd0);
    check({tag, "_locked_out"}, {31'b0, locked_out}, 32'd0);
    check({tag, "_index"}, {30'b0, digit_index}, 32'd0);
    check({tag, "_fail_count"}, {30'b0, fail_count}, 32'd0);
    check({tag, "_fail_pulse"}, {31'b0, fail_pulse}, 32'd0);
    check({tag, "_accepted"}, {31'b0, digit_accepted}, 32'd0);
    $display("%s outputs enable=%0b unlocked=%0b locked_out=%0b fail_count=%0d",
             tag, enable_digit_select, unlocked, locked_out, fail_count);
  endtask

  initial begin
    int n;
    logic acc_seen;

    tbl[0] = '{16'h1235, 1'b0, 1'b0, 2'd1};
    tbl[1] = '{16'h1234, 1'b1, 1'b0, 2'd0};
    tbl[2] = '{16'h0000, 1'b0, 1'b0, 2'd1};
    tbl[3] = '{16'h12A4, 1'b0, 1'b0, 2'd2};
    tbl[4] = '{16'h1234, 1'b1, 1'b0, 2'd0};
    tbl[5] = '{16'h9234, 1'b0, 1'b0, 2'd1};
    tbl[6] = '{16'h1234, 1'b1, 1'b0, 2'd0};

    sys_reset = 1'b1;
    current_digit = 4'd0;
    enter_pulse = 1'b0; clear_pulse = 1'b0; lock_pulse = 1'b0; program_pulse = 1'b0;
    #12;
    check_reset_outputs("reset");
    tick();
    sys_reset = 1'b0;
    tick();

    for (int t = 0; t < 7; t++) begin
      attempt(tbl[t].code, tbl[t].exp_unlock, tbl[t].exp_lockout, tbl[t].exp_fails);
      if (tbl[t].exp_unlock) relock();
    end

    // Unlock window length and auto-relock
    attempt(16'h1234, 1'b1, 1'b0, 2'd0);
    n = 1;
    for (int k = 0; k < 100 && unlocked; k++) begin
      tick();
      if (unlocked) n++;
    end
    check("unlock_cycles", n, 32'd20);
    check("auto_relock_enable", {31'b0, enable_digit_select}, 32'd1);
    $display("unlock window cycles=%0d", n);

    // Three wrong codes lock out entry; enters are ignored throughout
    attempt(16'h1235, 1'b0, 1'b0, 2'd1);
    attempt(16'h1235, 1'b0, 1'b0, 2'd2);
    attempt(16'h1235, 1'b0, 1'b1, 2'd3);
    check("lockout_enable", {31'b0, enable_digit_select}, 32'd0);
    n = 1;
    acc_seen = 1'b0;
    current_digit = 4'd1;
    enter_pulse = 1'b1;
    for (int k = 0; k < 200 && locked_out; k++) begin
      tick();
      if (digit_accepted) acc_seen = 1'b1;
      if (locked_out) n++;
    end
    enter_pulse = 1'b0;
    check("lockout_cycles", n, 32'd50);
    check("lockout_enter_ignored", {31'b0, acc_seen}, 32'd0);
    check("post_lockout_fail_count", {30'b0, fail_count}, 32'd0);
    check("post_lockout_index", {30'b0, digit_index}, 32'd0);
    $display("lockout cycles=%0d fail_count=%0d", n, fail_count);

    // Clear wins over same-cycle enter
    press(4'd1);
    press(4'd2);
    check("index_before_clear", {30'b0, digit_index}, 32'd2);
    current_digit = 4'd3;
    enter_pulse = 1'b1;
    clear_pulse = 1'b1;
    tick();
    enter_pulse = 1'b0;
    clear_pulse = 1'b0;
    check("clear_index", {30'b0, digit_index}, 32'd0);
    check("clear_no_accept", {31'b0, digit_accepted}, 32'd0);
    $display("clear with enter digit_index=%0d", digit_index);
    attempt(16'h1234, 1'b1, 1'b0, 2'd0);
    relock();

    // Aborted programming keeps the old code
    attempt(16'h1234, 1'b1, 1'b0, 2'd0);
    start_program();
    press(4'd9);
    press(4'd0);
    lock_pulse = 1'b1;
    tick();
    lock_pulse = 1'b0;
    check("abort_index", {30'b0, digit_index}, 32'd0);
    check("abort_unlocked", {31'b0, unlocked}, 32'd0);
    $display("program aborted digit_index=%0d", digit_index);
    attempt(16'h1234, 1'b1, 1'b0, 2'd0);
    relock();

    // Full programming to 9007
    attempt(16'h1234, 1'b1, 1'b0, 2'd0);
    start_program();
    press(4'd9);
    press(4'd0);
    press(4'd0);
    press(4'd7);
    check("program_done_index", {30'b0, digit_index}, 32'd0);
    attempt(16'h1234, 1'b0, 1'b0, 2'd1);
    attempt(16'h9007, 1'b1, 1'b0, 2'd0);
    relock();

    // Asynchronous reset after programming restores the default code
    attempt(16'h1111, 1'b0, 1'b0, 2'd1);
    sys_reset = 1'b1;
    #1;
    check_reset_outputs("reset_after_program");
    #2;
    sys_reset = 1'b0;
    tick();
    attempt(16'h9007, 1'b0, 1'b0, 2'd1);
    attempt(16'h1234, 1'b1, 1'b0, 2'd0);
    relock();

    // Asynchronous reset mid-lockout
    attempt(16'h5555, 1'b0, 1'b0, 2'd1);
    attempt(16'h5555, 1'b0, 1'b0, 2'd2);
    attempt(16'h5555, 1'b0, 1'b1, 2'd3);
    for (int k = 0; k < 5; k++) tick();
    check("still_locked", {31'b0, locked_out}, 32'd1);
    sys_reset = 1'b1;
    #1;
    check_reset_outputs("reset_in_lockout");
    #2;
    sys_reset = 1'b0;
    tick();
    attempt(16'h1234, 1'b1, 1'b0, 2'd0);
    relock();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
